// File: rtl/tick_stretch.sv
`default_nettype none
// tick_stretch: stretches single-cycle ticks into 2^N-cycle LED pulses separated by 2^N-cycle gaps,
// with a saturating queue of pending ticks and a sticky overflow flag.
module tick_stretch #(
  parameter int N = 22,
  parameter int P = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick_in,
  input  logic         clr,
  output logic         led,
  output logic         busy,
  output logic [P-1:0] pend,
  output logic         ovf
);

  localparam logic [1:0]   S_IDLE = 2'd0;
  localparam logic [1:0]   S_ON   = 2'd1;
  localparam logic [1:0]   S_GAP  = 2'd2;
  localparam logic [N-1:0] Q_ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [P-1:0] P_ONE  = {{(P-1){1'b0}}, 1'b1};

  logic [1:0]   state_q, state_d;
  logic [N-1:0] q_q, q_d;
  logic [P-1:0] pend_q, pend_d;
  logic         ovf_q, ovf_d;
  logic         gap_to_on;
  logic         q_zero;
  logic         pend_full;

  assign q_zero    = (q_q == '0);
  assign pend_full = (pend_q == {P{1'b1}});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    q_d       = q_q;
    pend_d    = pend_q;
    ovf_d     = ovf_q;
    gap_to_on = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tick_in) begin
          state_d = S_ON;
          q_d     = '1;
        end
      end
      S_ON: begin
        if (!q_zero) begin
          q_d = q_q - Q_ONE;
        end else begin
          state_d = S_GAP;
          q_d     = '1;
        end
      end
      S_GAP: begin
        if (!q_zero) begin
          q_d = q_q - Q_ONE;
        end else if ((pend_q != '0) || tick_in) begin
          state_d   = S_ON;
          q_d       = '1;
          gap_to_on = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        q_d     = '0;
      end
    endcase

    // A tick arriving as the gap ends is replayed at once: either consumed directly
    // (empty queue) or swapped for the oldest queued entry, so pend is unchanged.
    if ((state_q == S_ON) || (state_q == S_GAP)) begin
      if (tick_in && !gap_to_on) begin
        if (!pend_full) begin
          pend_d = pend_q + P_ONE;
        end else begin
          ovf_d = 1'b1;
        end
      end else if (!tick_in && gap_to_on) begin
        pend_d = pend_q - P_ONE;
      end
    end

    if (clr) begin
      state_d = S_IDLE;
      q_d     = '0;
      pend_d  = '0;
      ovf_d   = 1'b0;
    end
  end

  always_comb begin
    led  = (state_q == S_ON);
    busy = (state_q != S_IDLE);
    pend = pend_q;
    ovf  = ovf_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_tick_stretch.sv
`default_nettype none
// Bench for tick_stretch (N=3, P=2): vector table, corner-case sequences, and random
// stimulus compared against a phase/elapsed-time model of the pulse train.
module tb_tick_stretch;

  localparam int N    = 3;
  localparam int P    = 2;
  localparam int LEN  = 1 << N;
  localparam int MAXQ = (1 << P) - 1;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         tick_in = 1'b0;
  logic         clr = 1'b0;
  logic         led, busy, ovf;
  logic [P-1:0] pend;

  int checks = 0;
  int failures = 0;

  // reference model: phase 0=idle 1=on 2=gap, t = cycles spent in the phase so far
  int m_ph, m_t, m_pend;
  bit m_ovf;
  bit use_model;

  tick_stretch #(.N(N), .P(P)) dut (
    .clk(clk), .reset(reset), .tick_in(tick_in), .clr(clr),
    .led(led), .busy(busy), .pend(pend), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       tick;
    logic       clr;
    int         reps;
    logic       led;
    logic       busy;
    logic [1:0] pend;
    logic       ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input int e_led, input int e_busy,
                          input int e_pend, input int e_ovf);
    chk({tag, ".led"}, int'(led), e_led);
    chk({tag, ".busy"}, int'(busy), e_busy);
    chk({tag, ".pend"}, int'(pend), e_pend);
    chk({tag, ".ovf"}, int'(ovf), e_ovf);
  endtask

  task automatic model_reset();
    m_ph = 0; m_t = 0; m_pend = 0; m_ovf = 1'b0;
  endtask

  task automatic model_queue_tick();
    if (m_pend < MAXQ) m_pend++;
    else m_ovf = 1'b1;
  endtask

  task automatic model_step(input bit tk, input bit cl);
    if (cl) begin
      model_reset();
    end else begin
      case (m_ph)
        0: if (tk) begin m_ph = 1; m_t = 1; end
        1: begin
          if (tk) model_queue_tick();
          if (m_t < LEN) m_t++;
          else begin m_ph = 2; m_t = 1; end
        end
        default: begin
          if (m_t < LEN) begin
            m_t++;
            if (tk) model_queue_tick();
          end else if (m_pend > 0 || tk) begin
            m_ph = 1; m_t = 1;
            if (!tk) m_pend--;
          end else begin
            m_ph = 0; m_t = 0;
          end
        end
      endcase
    end
  endtask

  task automatic step(input bit tk, input bit cl);
    tick_in = tk;
    clr = cl;
    model_step(tk, cl);
    @(posedge clk);
    #1;
    if (use_model)
      chk_outs("model", (m_ph == 1) ? 1 : 0, (m_ph != 0) ? 1 : 0, m_pend, int'(m_ovf));
  endtask

  initial begin
    use_model = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_outs("reset", 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // single pulse, then a burst that saturates the queue, then clr
    tbl.push_back('{1'b1, 1'b0, 1, 1'b1, 1'b1, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 7, 1'b1, 1'b1, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 8, 1'b0, 1'b1, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 2, 1'b0, 1'b0, 2'd0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1, 1'b1, 1'b1, 2'd0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1, 1'b1, 1'b1, 2'd1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1, 1'b1, 1'b1, 2'd2, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1, 1'b1, 1'b1, 2'd3, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1, 1'b1, 1'b1, 2'd3, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 3, 1'b1, 1'b1, 2'd3, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 8, 1'b0, 1'b1, 2'd3, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 8, 1'b1, 1'b1, 2'd2, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 8, 1'b0, 1'b1, 2'd2, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 8, 1'b1, 1'b1, 2'd1, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 8, 1'b0, 1'b1, 2'd1, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 8, 1'b1, 1'b1, 2'd0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 8, 1'b0, 1'b1, 2'd0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 3, 1'b0, 1'b0, 2'd0, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 1, 1'b0, 1'b0, 2'd0, 1'b0});

    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].reps; r++) begin
        step(tbl[i].tick, tbl[i].clr);
        chk_outs($sformatf("vec%0d.%0d", i, r), int'(tbl[i].led), int'(tbl[i].busy),
                 int'(tbl[i].pend), int'(tbl[i].ovf));
      end
    end

    // tick on the last gap cycle with an empty queue: straight back to ON
    step(1'b1, 1'b0);
    for (int k = 1; k < 2 * LEN; k++) step(1'b0, 1'b0);
    chk_outs("gapend0.pre", 0, 1, 0, 0);
    step(1'b1, 1'b0);
    chk_outs("gapend0.on", 1, 1, 0, 0);
    for (int k = 1; k < LEN; k++) step(1'b0, 1'b0);
    chk_outs("gapend0.last_on", 1, 1, 0, 0);
    step(1'b0, 1'b0);
    chk_outs("gapend0.gap", 0, 1, 0, 0);
    step(1'b0, 1'b1);

    // same with a full queue: net zero change, no overflow
    step(1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0);
    chk_outs("gapend3.full", 1, 1, 3, 0);
    for (int k = 4; k < 2 * LEN; k++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk_outs("gapend3.on", 1, 1, 3, 0);
    step(1'b0, 1'b1);

    // clr mid-ON with pend=2 and a coincident tick
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk_outs("clr.pre", 1, 1, 2, 0);
    step(1'b1, 1'b1);
    chk_outs("clr.post", 0, 0, 0, 0);
    for (int k = 0; k < 3 * LEN; k++) begin
      step(1'b0, 1'b0);
      chk("clr.quiet_led", int'(led), 0);
    end

    // asynchronous reset in the middle of a gap
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    for (int k = 2; k < LEN + 3; k++) step(1'b0, 1'b0);
    chk_outs("arst.pre", 0, 1, 1, 0);
    #2;
    reset = 1'b0;
    #1;
    chk_outs("arst.now", 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    #2;
    step(1'b1, 1'b0);
    for (int k = 1; k < LEN; k++) begin
      chk("arst.pulse_led", int'(led), 1);
      step(1'b0, 1'b0);
    end
    chk("arst.pulse_last", int'(led), 1);
    step(1'b0, 1'b0);
    chk_outs("arst.after", 0, 1, 0, 0);
    step(1'b0, 1'b1);

    // random traffic against the model
    model_reset();
    use_model = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0,
           ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
